// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   rx_state_t        - receiver FSM state encodings (RX_IDLE .. RX_BREAK)
//   UART_RX_DATA_ADDR - load address that pops the receive buffer
//   UART_RX_STAT_ADDR - load address of the status word
//   rx_stat_word()    - status word layout {29'b0, ovr, ferr, valid}
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0010;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0014;

    // Status word seen by the CPU at UART_RX_STAT_ADDR
    function automatic logic [31:0] rx_stat_word(input logic ovr, input logic ferr,
                                                 input logic valid);
        return {29'b0, ovr, ferr, valid};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, CPU pop/clear strobes and receive status.
//   uart_rx      - serial line (idle high), driven by the outside world
//   uart_rd_i    - one-cycle pop strobe from the load path
//   uart_clr_i   - clears the sticky error flags
//   uart_dat_o   - byte at the buffer head
//   uart_valid_o - buffer non-empty
//   uart_ferr_o  - sticky framing error
//   uart_ovr_o   - sticky overrun
// slave modport is the receiver side, master the CPU/pin side.
interface uart_rx_if;
    logic       uart_rx;
    logic       uart_rd_i;
    logic       uart_clr_i;
    logic [7:0] uart_dat_o;
    logic       uart_valid_o;
    logic       uart_ferr_o;
    logic       uart_ovr_o;

    modport slave (
        input  uart_rx, uart_rd_i, uart_clr_i,
        output uart_dat_o, uart_valid_o, uart_ferr_o, uart_ovr_o
    );

    modport master (
        output uart_rx, uart_rd_i, uart_clr_i,
        input  uart_dat_o, uart_valid_o, uart_ferr_o, uart_ovr_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer with simultaneous push/pop.
//   DEPTH     - entries; 1 gives a holding register, otherwise a power of two
//   clk, rst  - clock, synchronous active-high reset
//   push      - write din (dropped when full unless a pop frees a slot)
//   pop       - remove the head (ignored when empty)
//   dout      - head byte, from registered storage
//   valid     - buffer non-empty
//   ovr_set_c - combinational pulse: push was dropped this cycle
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ovr_set_c
);

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    // A pop in the same cycle frees a slot for a push even when full
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ovr_set_c = push && !do_push;

    if (DEPTH == 1) begin : g_reg
        logic [7:0] hold_q;
        logic       vld_q;

        // Single holding register; a simultaneous push replaces the popped byte
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= 8'h00;
                vld_q  <= 1'b0;
            end else begin
                if (do_push) begin
                    hold_q <= din;
                    vld_q  <= 1'b1;
                end else if (do_pop) begin
                    vld_q  <= 1'b0;
                end
            end
        end

        assign empty = !vld_q;
        assign full  = vld_q;
        assign dout  = hold_q;
        assign valid = vld_q;
    end else begin : g_ring
        localparam int unsigned PTR_W = $clog2(DEPTH);
        localparam int unsigned CNT_W = $clog2(DEPTH + 1);

        logic [7:0]       mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_n;
        logic             valid_q;

        always_comb begin
            count_n = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end

        // Circular buffer; pointers wrap naturally since DEPTH is a power of two
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[i] <= 8'h00;
                end
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
                valid_q <= 1'b0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count_q <= count_n;
                valid_q <= (count_n != '0);
            end
        end

        assign empty = (count_q == '0);
        assign full  = (count_q == CNT_W'(DEPTH));
        assign dout  = mem[rd_ptr];
        assign valid = valid_q;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, byte buffer and
// sticky framing-error / overrun flags.
//   CLKS_PER_BIT - clock cycles per bit (>= 4)
//   FIFO_DEPTH   - buffer depth (power of two) when UART_RX_FIFO_EN is defined
//   sys_clk_i    - clock
//   sys_rst_i    - synchronous active-high reset
//   bus          - uart_rx_if.slave: line, pop/clear strobes, data and status
// Build option: `define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer;
// otherwise a single holding register is used.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic    sys_clk_i,
    input  logic    sys_rst_i,
    uart_rx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned EFF_DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned EFF_DEPTH = 1;
`endif

    logic             rx_meta;
    logic             rxs;
    rx_state_t        state;
    rx_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       idx;
    logic [2:0]       idx_n;
    logic [7:0]       sh;
    logic [7:0]       sh_n;
    logic             push_c;
    logic             ferr_set_c;
    logic             ovr_set_c;
    logic             ferr_q;
    logic             ovr_q;
    logic [7:0]       fifo_dat;
    logic             fifo_valid;

    // Two-flop synchronizer; idle-high reset avoids a false start bit
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx;
            rxs     <= rx_meta;
        end
    end

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= RX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
        end
    end

    // Next-state logic: start check at half a bit, then one bit period per sample
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        idx_n      = idx;
        sh_n       = sh;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    sh_n  = {rxs, sh[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (rxs) begin
                        push_c  = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_n    = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Wait for the line to return high so a held-low line is one error
                cnt_n = '0;
                if (rxs) begin
                    state_n = RX_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = RX_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH(EFF_DEPTH)
    ) u_fifo (
        .clk      (sys_clk_i),
        .rst      (sys_rst_i),
        .push     (push_c),
        .pop      (bus.uart_rd_i),
        .din      (sh),
        .dout     (fifo_dat),
        .valid    (fifo_valid),
        .ovr_set_c(ovr_set_c)
    );

    // Sticky flags; a set event in the same cycle as a clear wins
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_set_c ? 1'b1 : (bus.uart_clr_i ? 1'b0 : ferr_q);
            ovr_q  <= ovr_set_c  ? 1'b1 : (bus.uart_clr_i ? 1'b0 : ovr_q);
        end
    end

    assign bus.uart_dat_o   = fifo_dat;
    assign bus.uart_valid_o = fifo_valid;
    assign bus.uart_ferr_o  = ferr_q;
    assign bus.uart_ovr_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, self-checking bench for uart_rx (CLKS_PER_BIT = 16).
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Cycles from driving the start bit low to the first cycle valid is high
    localparam int LATENCY = 2 + HALF + 9 * CPB + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_dat;
        logic       exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    logic [7:0] rise_dat = 8'h00;
    logic valid_d = 1'b0;
    vec_t vecs [5];

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle and data of each rising edge of valid
    always @(negedge clk) begin
        if (bus.uart_valid_o && !valid_d) begin
            rise_cyc = cyc;
            rise_dat = bus.uart_dat_o;
        end
        valid_d = bus.uart_valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; the line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop);
        bus.uart_rx = 1'b0;
        tick(CPB);
        for (int k = 0; k < 8; k++) begin
            bus.uart_rx = b[k];
            tick(CPB);
        end
        bus.uart_rx = stop;
        tick(CPB);
    endtask

    task automatic pulse_rd();
        bus.uart_rd_i = 1'b1;
        tick(1);
        bus.uart_rd_i = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.uart_clr_i = 1'b1;
        tick(1);
        bus.uart_clr_i = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        bus.uart_rx    = 1'b1;
        bus.uart_rd_i  = 1'b0;
        bus.uart_clr_i = 1'b0;

        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_dat: 8'h00, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_dat: 8'hFF, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_dat: 8'h00, exp_ferr: 1'b1};
        vecs[3] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_dat: 8'h81, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_dat: 8'h5A, exp_ferr: 1'b0};

        // Reset state
        tick(3);
        check("rst_valid", 32'(bus.uart_valid_o), 0);
        check("rst_ferr",  32'(bus.uart_ferr_o),  0);
        check("rst_ovr",   32'(bus.uart_ovr_o),   0);
        check("rst_dat",   32'(bus.uart_dat_o),   0);
        rst = 1'b0;
        tick(2);

        // Frame 0xA5: exact latency of valid and data at the rising edge
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(2);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LATENCY));
        check("a5_rise_dat", 32'(rise_dat), 32'hA5);
        check("a5_valid", 32'(bus.uart_valid_o), 1);
        pulse_rd();
        check("a5_pop_valid", 32'(bus.uart_valid_o), 0);

        // Pop while empty has no effect
        pulse_rd();
        check("empty_pop_valid", 32'(bus.uart_valid_o), 0);
        check("empty_pop_ovr",   32'(bus.uart_ovr_o),   0);

        // Short low glitch on an idle line
        bus.uart_rx = 1'b0;
        tick(4);
        bus.uart_rx = 1'b1;
        tick(3 * CPB);
        check("glitch_valid", 32'(bus.uart_valid_o), 0);
        check("glitch_ferr",  32'(bus.uart_ferr_o),  0);

        // Table of frames
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            bus.uart_rx = 1'b1;
            tick(CPB);
            check($sformatf("vec%0d_valid", i), 32'(bus.uart_valid_o), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_dat", i), 32'(bus.uart_dat_o), 32'(vecs[i].exp_dat));
                pulse_rd();
            end
            check($sformatf("vec%0d_ferr", i), 32'(bus.uart_ferr_o), 32'(vecs[i].exp_ferr));
            pulse_clr();
            check($sformatf("vec%0d_empty", i), 32'(bus.uart_valid_o), 0);
        end

        // Bad stop bit, line held low, then a good frame
        send_frame(8'h3C, 1'b0);
        tick(40);
        check("brk_ferr",  32'(bus.uart_ferr_o),  1);
        check("brk_valid", 32'(bus.uart_valid_o), 0);
        bus.uart_rx = 1'b1;
        tick(4);
        send_frame(8'h55, 1'b1);
        tick(2);
        check("brk_55_valid", 32'(bus.uart_valid_o), 1);
        check("brk_55_dat",   32'(bus.uart_dat_o),   32'h55);
        check("brk_ferr_sticky", 32'(bus.uart_ferr_o), 1);
        pulse_rd();
        pulse_clr();
        check("brk_ferr_clr", 32'(bus.uart_ferr_o), 0);

        // Clear in the same cycle as the framing-error sample: set wins
        fork
            send_frame(8'h3C, 1'b0);
            begin
                tick(2 + HALF + 9 * CPB);
                bus.uart_clr_i = 1'b1;
                tick(1);
                bus.uart_clr_i = 1'b0;
            end
        join
        check("setclr_ferr", 32'(bus.uart_ferr_o), 1);
        bus.uart_rx = 1'b1;
        tick(CPB);
        pulse_clr();
        check("setclr_ferr_clr", 32'(bus.uart_ferr_o), 0);

        // Overrun: five frames with no reads
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(i + 1), 1'b1);
        end
        tick(2);
        check("ovr_flag", 32'(bus.uart_ovr_o), 1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovr_valid%0d", i), 32'(bus.uart_valid_o), 1);
            check($sformatf("ovr_dat%0d", i),   32'(bus.uart_dat_o),   32'(i + 1));
            pulse_rd();
        end
        check("ovr_drained", 32'(bus.uart_valid_o), 0);
        pulse_clr();
        check("ovr_clr", 32'(bus.uart_ovr_o), 0);

        // Full buffer, pop in the exact push cycle
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(8'h10 + i), 1'b1);
        end
        tick(2);
        check("full_no_ovr", 32'(bus.uart_ovr_o), 0);
        fork
            send_frame(8'h99, 1'b1);
            begin
                tick(2 + HALF + 9 * CPB);
                bus.uart_rd_i = 1'b1;
                tick(1);
                bus.uart_rd_i = 1'b0;
            end
        join
        tick(2);
        check("pp_ovr", 32'(bus.uart_ovr_o), 0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'h99;
            check($sformatf("pp_valid%0d", i), 32'(bus.uart_valid_o), 1);
            check($sformatf("pp_dat%0d", i),   32'(bus.uart_dat_o),   32'(exp_b));
            pulse_rd();
        end
        check("pp_drained", 32'(bus.uart_valid_o), 0);

        // Load non-zero state, then reset during data bit 3 of a frame
        send_frame(8'h42, 1'b1);
        send_frame(8'h3C, 1'b0);
        bus.uart_rx = 1'b1;
        tick(CPB);
        check("pre_rst_valid", 32'(bus.uart_valid_o), 1);
        check("pre_rst_ferr",  32'(bus.uart_ferr_o),  1);
        fork
            send_frame(8'hF8, 1'b1);
            begin
                tick(2 + HALF + 3 * CPB + 10);
                rst = 1'b1;
                tick(1);
                check("mid_rst_valid", 32'(bus.uart_valid_o), 0);
                check("mid_rst_ferr",  32'(bus.uart_ferr_o),  0);
                check("mid_rst_ovr",   32'(bus.uart_ovr_o),   0);
                check("mid_rst_dat",   32'(bus.uart_dat_o),   0);
                rst = 1'b0;
            end
        join
        tick(2);
        check("aborted_frame", 32'(bus.uart_valid_o), 0);
        send_frame(8'h7E, 1'b1);
        tick(2);
        check("post_rst_valid", 32'(bus.uart_valid_o), 1);
        check("post_rst_dat",   32'(bus.uart_dat_o),   32'h7E);
        check("post_rst_ferr",  32'(bus.uart_ferr_o),  0);
        check("post_rst_ovr",   32'(bus.uart_ovr_o),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart of the CPU's byte-wide UART transmitter. It recovers 8N1 frames from the external `uart_rx` pin using mid-bit sampling and buffers received bytes. The CPU reads the buffered bytes through a memory-mapped load in the memory-access stage. It also reports sticky framing-error and overrun status.

## Interface
- `CLKS_PER_BIT`, default 868: sysclk cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: receive buffer depth, power of two. Used only with `UART_RX_FIFO_EN`.
- `sys_clk_i`, in, 1: single clock.
- `sys_rst_i`, in, 1: reset; synchronous, active-high.
- `uart_rx`, in, 1: asynchronous serial line; idle high.
- `uart_rd_i`, in, 1: pop strobe, asserted for one cycle per load from the RX data address.
- `uart_clr_i`, in, 1: clears the sticky error flags.
- `uart_dat_o`, out, 8: byte at the buffer head. Undefined when `uart_valid_o` = 0.
- `uart_valid_o`, out, 1: buffer non-empty.
- `uart_ferr_o`, out, 1: sticky framing error.
- `uart_ovr_o`, out, 1: sticky overrun.

## Operation
**Input synchronizer**
- Two-flop synchronizer on `uart_rx`; both flops reset to 1.
- All FSM decisions use the synchronized line `rxs`.

**FSM states:** IDLE, START, DATA, STOP, BREAK. Bit counter `cnt` (width clog2(CLKS_PER_BIT)); bit index `idx` (3 bits). Let HALF = CLKS_PER_BIT/2, floored.
- IDLE: when `rxs` = 0, go to START with `cnt` = 0.
- START: when `cnt` = HALF−1, sample `rxs`.
  - `rxs` = 0: go to DATA with `cnt` = 0, `idx` = 0.
  - `rxs` = 1: treat as a glitch and return to IDLE.
- DATA: when `cnt` = CLKS_PER_BIT−1, shift `rxs` in LSB-first and clear `cnt`. After `idx` = 7, go to STOP.
- STOP: when `cnt` = CLKS_PER_BIT−1, sample `rxs`.
  - `rxs` = 1: push the byte and go to IDLE.
  - `rxs` = 0: set `uart_ferr_o`, discard the byte, go to BREAK.
- BREAK: stay until `rxs` = 1, then go to IDLE. This prevents a held-low line from retriggering frames.

**Buffer rules**
- Push when full: the byte is dropped and `uart_ovr_o` is set.
- Pop (`uart_rd_i`) when empty: ignored, no side effect.
- Push and pop in the same cycle while full: the pop frees a slot, the push succeeds, no overrun.
- Push and pop in the same cycle while holding exactly one entry: that entry leaves and the new byte becomes the head.

**Flags**
- `uart_clr_i` clears both sticky flags.
- If a set event and `uart_clr_i` occur in the same cycle, the set wins.

**Reset**
- Applies at any point, including mid-frame.
- FSM goes to IDLE; counters zeroed; buffer empty; all flags 0; synchronizer flops to 1.
- Reset values of outputs: `uart_valid_o` = 0, `uart_ferr_o` = 0, `uart_ovr_o` = 0, `uart_dat_o` = 0.

## Timing
- Define t0 as the first cycle IDLE observes `rxs` = 0. This is 2 cycles after the pin edge.
- Sample points:
  - start-bit check at t0+HALF;
  - data bit k (k = 0..7) at t0+HALF+(k+1)·CLKS_PER_BIT;
  - stop bit at t0+HALF+9·CLKS_PER_BIT.
- `uart_valid_o` rises, and `uart_dat_o` is valid, in the cycle after the stop sample.
- The next frame's start bit can be detected in the cycle after the STOP→IDLE transition.
- `uart_dat_o` is driven from registered storage; it reflects the head in the same cycle `uart_valid_o` is high.
- After a pop, the next entry appears on the following cycle.
- Error flags assert in the cycle after the causing sample or push.

## Configuration
- `UART_RX_FIFO_EN` defined: circular FIFO of `FIFO_DEPTH` entries, with read and write pointers plus a count. Full means count = FIFO_DEPTH.
- Not defined: a single holding register plus a valid bit, i.e. depth 1 with the same push/pop/overrun rules. `FIFO_DEPTH` is ignored.

## Structure
- Shared define file holds:
  - FSM state encodings (`RX_IDLE` … `RX_BREAK`);
  - `UART_RX_DATA_ADDR` and `UART_RX_STAT_ADDR`. The status word is {29'b0, ovr, ferr, valid}.
- The load path decodes `UART_RX_DATA_ADDR` to generate `uart_rd_i`.
- Sub-module `uart_rx_fifo` handles storage, count, full/empty, and simultaneous push/pop. It is instantiated under either configuration with an effective depth of 1 or `FIFO_DEPTH`.
- The FSM and synchronizer stay in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT = 16, HALF = 8.
- Frame 0xA5 → `uart_valid_o` rises at t0+8+144+1 with `uart_dat_o` = 0xA5; one `uart_rd_i` pulse → valid = 0.
- 4-cycle low glitch on an idle line → FSM returns to IDLE; no valid, no ferr.
- Frame 0x3C with the stop bit low → ferr = 1, valid stays 0. Line then held low 40 cycles, released, frame 0x55 sent → 0x55 received and ferr remains 1 until `uart_clr_i`.
- With the FIFO enabled (depth 4): frames 0x01..0x05 with no reads → pops return 0x01..0x04 in order, ovr = 1. With the FIFO disabled: only 0x01 is held, ovr = 1.
- Buffer full, `uart_rd_i` pulsed in the exact push cycle → no overrun, and the new byte ends up last in order.
- `sys_rst_i` asserted during data bit 3 → all outputs 0 the next cycle; a following frame 0x7E is received correctly.
